// File: rtl/top.sv
// Single-cycle RV32I subset core (lw, sw, add, sub, and, or, slt, addi, beq).
// Register file, instruction ROM and data memory keep their contents across reset.

module reg_file (
    input  logic        clk,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] registers [0:31];

    always_ff @(posedge clk) begin
        if (we && wa != 5'd0) registers[wa] <= wd;
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : registers[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : registers[ra2];
endmodule

module inst_mem #(
    parameter int DEPTH = 64
) (
    input  logic [29:0] word_addr,
    output logic [31:0] instr
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] rom [0:DEPTH-1];

    // Fetches past the end of the ROM return 0, which decodes as a no-op.
    assign instr = ({2'b00, word_addr} < 32'(DEPTH)) ? rom[word_addr[AW-1:0]] : 32'd0;
endmodule

module data_mem #(
    parameter int DEPTH = 16384
) (
    input  logic        clk,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [0:DEPTH-1];
    logic        in_range;

    assign in_range = addr < 32'(DEPTH);
    assign rd       = in_range ? mem[addr[AW-1:0]] : 32'd0;

    always_ff @(posedge clk) begin
        if (we && in_range) mem[addr[AW-1:0]] <= wd;
    end
endmodule

module top #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 16384
) (
    input logic CLK,
    input logic rst
);
    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    logic [31:0] PC, PCNext, Instr, ImmExt, SrcA, SrcB, WriteData, Result;
    logic [31:0] pc_q, pc_d;
    logic [31:0] alu_result, read_data;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic        reg_write, mem_write, alu_src_imm, is_lw, is_beq, branch_taken;
    alu_op_t     alu_op;

    assign opcode = Instr[6:0];
    assign funct3 = Instr[14:12];
    assign funct7 = Instr[31:25];

    // Strict decode: anything not recognised leaves every enable low.
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        alu_src_imm = 1'b0;
        is_lw       = 1'b0;
        is_beq      = 1'b0;
        alu_op      = ALU_ADD;
        case (opcode)
            7'b0000011: if (funct3 == 3'b010) begin
                reg_write = 1'b1; alu_src_imm = 1'b1; is_lw = 1'b1;
            end
            7'b0100011: if (funct3 == 3'b010) begin
                mem_write = 1'b1; alu_src_imm = 1'b1;
            end
            7'b0010011: if (funct3 == 3'b000) begin
                reg_write = 1'b1; alu_src_imm = 1'b1;
            end
            7'b0110011: begin
                case ({funct7, funct3})
                    10'b0000000_000: begin reg_write = 1'b1; alu_op = ALU_ADD; end
                    10'b0100000_000: begin reg_write = 1'b1; alu_op = ALU_SUB; end
                    10'b0000000_111: begin reg_write = 1'b1; alu_op = ALU_AND; end
                    10'b0000000_110: begin reg_write = 1'b1; alu_op = ALU_OR;  end
                    10'b0000000_010: begin reg_write = 1'b1; alu_op = ALU_SLT; end
                    default: ;
                endcase
            end
            7'b1100011: if (funct3 == 3'b000) begin
                is_beq = 1'b1; alu_op = ALU_SUB;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (opcode)
            7'b0100011: ImmExt = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
            7'b1100011: ImmExt = {{19{Instr[31]}}, Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            default:    ImmExt = {{20{Instr[31]}}, Instr[31:20]};
        endcase
    end

    assign SrcB = alu_src_imm ? ImmExt : WriteData;

    always_comb begin
        case (alu_op)
            ALU_SUB: alu_result = SrcA - SrcB;
            ALU_AND: alu_result = SrcA & SrcB;
            ALU_OR:  alu_result = SrcA | SrcB;
            ALU_SLT: alu_result = ($signed(SrcA) < $signed(SrcB)) ? 32'd1 : 32'd0;
            default: alu_result = SrcA + SrcB;
        endcase
    end

    assign Result       = is_lw ? read_data : alu_result;
    assign branch_taken = is_beq && (alu_result == 32'd0);

    always_comb begin
        pc_d = branch_taken ? (PC + ImmExt) : (PC + 32'd4);
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) pc_q <= 32'd0;
        else     pc_q <= pc_d;
    end

    assign PC     = pc_q;
    assign PCNext = pc_d;

    inst_mem #(.DEPTH(IMEM_DEPTH)) instMem (
        .word_addr (PC[31:2]),
        .instr     (Instr)
    );

    reg_file regFile (
        .clk (CLK),
        .we  (reg_write & ~rst),
        .ra1 (Instr[19:15]),
        .ra2 (Instr[24:20]),
        .wa  (Instr[11:7]),
        .wd  (Result),
        .rd1 (SrcA),
        .rd2 (WriteData)
    );

    data_mem #(.DEPTH(DMEM_DEPTH)) dataMem (
        .clk  (CLK),
        .we   (mem_write & ~rst),
        .addr (alu_result),
        .wd   (WriteData),
        .rd   (read_data)
    );
endmodule

// File: tb/tb_top.sv
// [TB] bench for the single-cycle core: directed sample program, reset checks,
// then a random program compared against an instruction-level reference model.

module tb_top;
    localparam int IMEM_DEPTH = 64;
    localparam int DMEM_DEPTH = 16384;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] prog   [0:IMEM_DEPTH-1];
    logic [31:0] m_regs [0:31];
    logic [31:0] m_mem  [0:DMEM_DEPTH-1];
    logic [31:0] m_pc;
    int unsigned written_addrs[$];

    top #(.IMEM_DEPTH(IMEM_DEPTH), .DMEM_DEPTH(DMEM_DEPTH)) dut (
        .CLK (CLK),
        .rst (rst)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
            $error("[TB] %s got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge CLK);
        @(negedge CLK);
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [6:0] op, input int imm, input int rs1,
                                          input logic [2:0] f3, input int rd);
        return {12'(imm), 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'b000, im[4:1], im[11], 7'b1100011};
    endfunction

    // Instruction-set-level reference: executes one instruction on the model state.
    task automatic model_step();
        logic [31:0] ins, a, b, val, addr, nxt;
        logic [31:0] imm_i, imm_s, imm_b;
        int          rd;
        logic        wr;
        ins   = ((m_pc >> 2) < 32'(IMEM_DEPTH)) ? prog[m_pc >> 2] : 32'd0;
        rd    = int'(ins[11:7]);
        a     = (ins[19:15] == 0) ? 32'd0 : m_regs[ins[19:15]];
        b     = (ins[24:20] == 0) ? 32'd0 : m_regs[ins[24:20]];
        imm_i = 32'($signed(ins[31:20]));
        imm_s = 32'($signed({ins[31:25], ins[11:7]}));
        imm_b = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        nxt   = m_pc + 4;
        wr    = 1'b0;
        val   = 32'd0;
        if (ins[6:0] == 7'b0000011 && ins[14:12] == 3'b010) begin
            addr = a + imm_i;
            val  = (addr < 32'(DMEM_DEPTH)) ? m_mem[addr] : 32'd0;
            wr   = 1'b1;
        end else if (ins[6:0] == 7'b0100011 && ins[14:12] == 3'b010) begin
            addr = a + imm_s;
            if (addr < 32'(DMEM_DEPTH)) begin
                m_mem[addr] = b;
                written_addrs.push_back(addr);
            end
        end else if (ins[6:0] == 7'b0010011 && ins[14:12] == 3'b000) begin
            val = a + imm_i; wr = 1'b1;
        end else if (ins[6:0] == 7'b0110011) begin
            wr = 1'b1;
            case ({ins[31:25], ins[14:12]})
                10'b0000000_000: val = a + b;
                10'b0100000_000: val = a - b;
                10'b0000000_111: val = a & b;
                10'b0000000_110: val = a | b;
                10'b0000000_010: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default:         wr  = 1'b0;
            endcase
        end else if (ins[6:0] == 7'b1100011 && ins[14:12] == 3'b000) begin
            if (a == b) nxt = m_pc + imm_b;
        end
        if (wr && rd != 0) m_regs[rd] = val;
        m_pc = nxt;
    endtask

    function automatic logic [31:0] random_instr();
        int kind, rs1, rs2, rd, imm;
        kind = $urandom_range(0, 9);
        rs1  = $urandom_range(0, 7);
        rs2  = $urandom_range(0, 31);
        rd   = $urandom_range(0, 31);
        imm  = $urandom_range(0, 4095) - 2048;
        case (kind)
            0: return enc_i(7'b0000011, imm, rs1, 3'b010, rd);
            1: return enc_s(imm, rs2, rs1);
            2: return enc_i(7'b0010011, imm, $urandom_range(0, 31), 3'b000, rd);
            3: return enc_r(7'b0000000, rs2, $urandom_range(0, 31), 3'b000, rd);
            4: return enc_r(7'b0100000, rs2, $urandom_range(0, 31), 3'b000, rd);
            5: return enc_r(7'b0000000, rs2, $urandom_range(0, 31), 3'b111, rd);
            6: return enc_r(7'b0000000, rs2, $urandom_range(0, 31), 3'b110, rd);
            7: return enc_r(7'b0000000, rs2, $urandom_range(0, 31), 3'b010, rd);
            8: return enc_b(($urandom_range(0, 8) - 4) * 4, ($urandom_range(0, 1) == 1) ? rs1 : rs2, rs1);
            default: return {20'($urandom), 5'(rd), 7'b0110111};
        endcase
    endfunction

    task automatic applyStimulus();
        for (int i = 0; i < IMEM_DEPTH; i++) prog[i] = 32'd0;
        prog[0]  = enc_i(7'b0000011, 8, 9, 3'b010, 1);
        prog[1]  = enc_i(7'b0000011, -4, 9, 3'b010, 2);
        prog[2]  = enc_i(7'b0000011, 4, 9, 3'b010, 3);
        prog[3]  = enc_r(7'b0100000, 1, 3, 3'b000, 3);
        prog[4]  = enc_r(7'b0000000, 2, 3, 3'b010, 4);
        prog[5]  = enc_b(-8, 0, 4);
        prog[6]  = enc_r(7'b0000000, 1, 2, 3'b000, 5);
        prog[7]  = enc_r(7'b0000000, 0, 5, 3'b111, 6);
        prog[8]  = enc_r(7'b0000000, 0, 5, 3'b110, 6);
        prog[9]  = enc_s(0, 6, 9);
        prog[10] = enc_i(7'b0010011, 2047, 0, 3'b000, 7);
        prog[11] = enc_i(7'b0010011, 5, 0, 3'b000, 0);
        prog[12] = 32'h0000_0537;
        for (int i = 0; i < IMEM_DEPTH; i++) dut.instMem.rom[i] = prog[i];
        for (int i = 0; i < 32; i++) dut.regFile.registers[i] = 32'd0;
        dut.regFile.registers[9]  = 32'h2004;
        dut.regFile.registers[10] = 32'h1234;
        dut.dataMem.mem[32'h2000] = 32'd5;
        dut.dataMem.mem[32'h2004] = 32'd0;
        dut.dataMem.mem[32'h2008] = 32'd10;
        dut.dataMem.mem[32'h200C] = 32'd1;
    endtask

    initial begin
        applyStimulus();

        // Mid-cycle reset pulse, released on the falling edge.
        @(posedge CLK);
        #2 rst = 1'b1;
        #1 checkOutput("pc_async_reset", dut.PC, 32'h0);
        @(negedge CLK);
        rst = 1'b0;
        #1;
        checkOutput("pc_at_release", dut.PC, 32'h0);
        checkOutput("pcnext_at_release", dut.PCNext, 32'h4);
        checkOutput("instr_first", dut.Instr, prog[0]);

        run_cycles(3);
        checkOutput("x1_lw", dut.regFile.registers[1], 32'd1);
        checkOutput("x2_lw", dut.regFile.registers[2], 32'd5);
        checkOutput("x3_lw", dut.regFile.registers[3], 32'd10);
        checkOutput("pc_after_loads", dut.PC, 32'd12);

        for (int k = 0; k < 6; k++) begin
            run_cycles(1);
            checkOutput("loop_sub_x3", dut.regFile.registers[3], 32'(9 - k));
            run_cycles(2);
            checkOutput("loop_beq_pc", dut.PC, (k < 5) ? 32'd12 : 32'd24);
        end
        checkOutput("loop_exit_x4", dut.regFile.registers[4], 32'd1);
        checkOutput("loop_exit_x3", dut.regFile.registers[3], 32'd4);

        run_cycles(2);
        checkOutput("add_x5", dut.regFile.registers[5], 32'd6);
        checkOutput("and_x6", dut.regFile.registers[6], 32'd0);
        run_cycles(1);
        checkOutput("or_x6", dut.regFile.registers[6], 32'd6);
        run_cycles(1);
        checkOutput("sw_mem", dut.dataMem.mem[32'h2004], 32'd6);
        run_cycles(1);
        checkOutput("addi_x7", dut.regFile.registers[7], 32'h7FF);
        run_cycles(1);
        checkOutput("x0_stays_zero", dut.regFile.registers[0], 32'd0);
        checkOutput("x0_read_srca", dut.SrcA, 32'd0);
        run_cycles(1);
        checkOutput("nop_x10", dut.regFile.registers[10], 32'h1234);
        checkOutput("nop_pc", dut.PC, 32'd52);

        // Restart, then reset again in the middle of the loop.
        #2 rst = 1'b1;
        @(negedge CLK);
        rst = 1'b0;
        run_cycles(5);
        checkOutput("loop2_pc", dut.PC, 32'd20);
        #2 rst = 1'b1;
        #1;
        checkOutput("loop2_pc_async", dut.PC, 32'h0);
        checkOutput("loop2_x3_kept", dut.regFile.registers[3], 32'd9);
        checkOutput("loop2_x1_kept", dut.regFile.registers[1], 32'd1);
        checkOutput("loop2_x5_kept", dut.regFile.registers[5], 32'd6);
        dut.regFile.registers[1] = 32'h55;
        run_cycles(1);
        checkOutput("no_write_in_reset", dut.regFile.registers[1], 32'h55);
        checkOutput("pc_held_in_reset", dut.PC, 32'h0);
        checkOutput("pcnext_in_reset", dut.PCNext, 32'h4);

        // Random program against the reference model, starting from known state.
        for (int i = 0; i < IMEM_DEPTH; i++) begin
            prog[i] = random_instr();
            dut.instMem.rom[i] = prog[i];
        end
        for (int i = 0; i < DMEM_DEPTH; i++) begin
            m_mem[i] = $urandom;
            dut.dataMem.mem[i] = m_mem[i];
        end
        m_regs[0] = 32'd0;
        dut.regFile.registers[0] = 32'd0;
        for (int i = 1; i < 32; i++) begin
            m_regs[i] = (i < 8) ? 32'($urandom_range(0, DMEM_DEPTH + 3000)) : $urandom;
            dut.regFile.registers[i] = m_regs[i];
        end
        m_pc = 32'd0;
        @(negedge CLK);
        rst = 1'b0;
        #1;
        for (int step = 0; step < 300; step++) begin
            checkOutput("rand_pc", dut.PC, m_pc);
            model_step();
            run_cycles(1);
            #1;
        end
        for (int i = 0; i < 32; i++) checkOutput($sformatf("rand_x%0d", i), dut.SrcA * 0 + ((i == 0) ? 32'd0 : dut.regFile.registers[i]), m_regs[i]);
        foreach (written_addrs[j]) checkOutput("rand_mem", dut.dataMem.mem[written_addrs[j]], m_mem[written_addrs[j]]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
